pll_supervisor: RTL
===================

PLL_SUPERVISOR -- requirements
Module: pll_supervisor

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 32, cycles pll_rst is held per PLL reset pulse (min 2).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000000, cycles allowed for lock before a retry (min 2).
REQ-003 SHALL have parameter STABLE_CYCLES, default 65536, consecutive locked cycles required before release (min 2).
REQ-004 SHALL have port refclk, input, 1, the single free-running clock (PLL reference clock, never a PLL output).
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port locked, input, 1, PLL lock indicator, asynchronous to refclk.
REQ-007 SHALL have port force_reset, input, 1, synchronous single-cycle request to re-reset the PLL.
REQ-008 SHALL have port pll_rst, output, 1, reset driven into the PLL rst input.
REQ-009 SHALL have port sys_rst, output, 1, system reset for logic clocked by PLL outputs.
REQ-010 SHALL have port ready, output, 1, high only when clocks are locked and stable.
REQ-011 SHALL have port state, output, 2, current FSM state encoding.
REQ-012 SHALL have port retry_cnt, output, 8, count of lock timeouts.
REQ-013 SHALL have port loss_cnt, output, 8, count of lock losses while running.

Function
REQ-014 SHALL synchronise locked through a two-flop synchroniser (locked_s); 2-cycle latency, both flops reset to 0.
REQ-015 SHALL implement FSM states PLLRST=0, WAIT=1, STABLE=2, RUN=3, with one shared down/up cycle counter of 24 bits.
REQ-016 PLLRST: counter increments from 0; at counter==RST_CYCLES-1 SHALL go to WAIT with counter cleared.
REQ-017 WAIT: if locked_s=1, SHALL go to STABLE with counter cleared; else at counter==TIMEOUT_CYCLES-1 SHALL increment retry_cnt and go to PLLRST.
REQ-018 STABLE: if locked_s=0, SHALL return to WAIT with counter cleared (timeout restarts); else at counter==STABLE_CYCLES-1 SHALL go to RUN.
REQ-019 RUN: if locked_s=0, SHALL increment loss_cnt and go to PLLRST with counter cleared.
REQ-020 force_reset=1 in any state SHALL go to PLLRST with counter cleared, without touching retry_cnt or loss_cnt; it overrides all other transitions in the same cycle.
REQ-021 Simultaneous locked_s drop and force_reset in RUN SHALL go to PLLRST and still increment loss_cnt.
REQ-022 retry_cnt and loss_cnt SHALL saturate at 255, never wrap.
REQ-023 Outputs SHALL be decoded directly from the state register: pll_rst=(state==PLLRST), sys_rst=(state!=RUN), ready=(state==RUN); no extra latency.

Reset
REQ-024 rst=1 SHALL asynchronously force state=PLLRST, counter=0, retry_cnt=0, loss_cnt=0, synchroniser=0, hence pll_rst=1, sys_rst=1, ready=0.
REQ-025 Assertion of rst mid-operation (any state) SHALL take effect immediately; after deassertion the sequence restarts at PLLRST counter 0.

Structure
REQ-026 SHALL place the state enum, its 2-bit encoding and counter-width constant (24) in package pll_supervisor_pkg.
REQ-027 SHALL instantiate one sub-module sync_2ff for the locked synchroniser; all other logic lives in pll_supervisor.

Verification (params RST_CYCLES=4, TIMEOUT_CYCLES=20, STABLE_CYCLES=8; edge N = Nth refclk rising edge after rst deassertion)
REQ-028 locked=1 throughout -> pll_rst falls at edge 4, WAIT at 4, STABLE at 5, ready/sys_rst release at edge 13, retry_cnt=0.
REQ-029 locked=0 throughout -> pll_rst pulses 4 cycles every 24 cycles; retry_cnt increments each pulse, saturates at 255 after 255 timeouts.
REQ-030 In RUN, locked drops for 1 cycle -> 2 cycles later state=PLLRST, ready=0, sys_rst=1, loss_cnt=1; re-lock yields ready again 13 edges after PLLRST entry.
REQ-031 In STABLE, locked glitches low at counter=5 -> return to WAIT, ready never asserts until 8 further consecutive locked cycles.
REQ-032 force_reset pulse in RUN -> PLLRST next edge, loss_cnt and retry_cnt unchanged; rst asserted in STABLE -> outputs to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pll_supervisor_pkg.sv
// Shared types and constants for the PLL reset supervisor.
package pll_supervisor_pkg;

  localparam int unsigned CNT_W = 24;

  typedef enum logic [1:0] {
    PLLRST = 2'd0,
    WAIT   = 2'd1,
    STABLE = 2'd2,
    RUN    = 2'd3
  } state_t;

endpackage

// File: rtl/pll_supervisor_sync_2ff.sv
// Two-flop synchroniser bringing an asynchronous level into the clk domain.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_supervisor.sv
// PLL reset sequencer: pulses pll_rst, waits for lock with timeout and retry,
// requires a stable-lock window before releasing the system reset.
module pll_supervisor
  import pll_supervisor_pkg::*;
#(
  parameter int unsigned RST_CYCLES     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned STABLE_CYCLES  = 65536
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       locked,
  input  logic       force_reset,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic [1:0] state,
  output logic [7:0] retry_cnt,
  output logic [7:0] loss_cnt
);

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

  state_t           st;
  logic [CNT_W-1:0] cnt;
  logic             locked_s;

  sync_2ff u_sync_locked (
    .clk (refclk),
    .rst (rst),
    .d   (locked),
    .q   (locked_s)
  );

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      st        <= PLLRST;
      cnt       <= '0;
      retry_cnt <= '0;
      loss_cnt  <= '0;
    end else begin
      // A lock loss in RUN is counted even when force_reset wins the transition.
      if (st == RUN && !locked_s && loss_cnt != 8'hFF)
        loss_cnt <= loss_cnt + 8'd1;

      if (force_reset) begin
        st  <= PLLRST;
        cnt <= '0;
      end else begin
        case (st)
          PLLRST: begin
            if (cnt == RST_LAST) begin
              st  <= WAIT;
              cnt <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          WAIT: begin
            if (locked_s) begin
              st  <= STABLE;
              cnt <= '0;
            end else if (cnt == TIMEOUT_LAST) begin
              if (retry_cnt != 8'hFF)
                retry_cnt <= retry_cnt + 8'd1;
              st  <= PLLRST;
              cnt <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          STABLE: begin
            if (!locked_s) begin
              st  <= WAIT;
              cnt <= '0;
            end else if (cnt == STABLE_LAST) begin
              st  <= RUN;
              cnt <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          RUN: begin
            if (!locked_s) begin
              st  <= PLLRST;
              cnt <= '0;
            end
          end
          default: begin
            st  <= PLLRST;
            cnt <= '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    state   = st;
    pll_rst = (st == PLLRST);
    sys_rst = (st != RUN);
    ready   = (st == RUN);
  end

endmodule
